// File: rtl/vga_pkg.sv
// Shared VGA timing constants and coordinate type for the timing generator and drawing stages.
// Holds no logic of its own apart from a small range-decode helper.
package vga_pkg;

  typedef logic [9:0] coord_t;

  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FP_DEF      = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BP_DEF      = 48;
  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FP_DEF      = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BP_DEF      = 33;

  localparam int H_TOTAL = H_VISIBLE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL = V_VISIBLE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  // Half-open interval test lo <= v < hi.
  function automatic logic in_range(coord_t v, coord_t lo, coord_t hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen_sync_delay.sv
// Reset-to-ones shift register aligning sync pulses with downstream colour latency.
// Latency DEPTH clocks (DEPTH=0 is a wire); free-running with no backpressure.
module sync_delay #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_dat,
  output logic [WIDTH-1:0] out_dat
);

  generate
    if (DEPTH == 0) begin : g_bypass
      assign out_dat = in_dat;
    end else begin : g_pipe
      logic [WIDTH-1:0] pipe_q [DEPTH];
      logic [WIDTH-1:0] pipe_d [DEPTH];

      always_comb begin
        pipe_d[0] = in_dat;
        for (int i = 1; i < DEPTH; i++) begin
          pipe_d[i] = pipe_q[i-1];
        end
      end

      // Ones on reset keeps the active-low syncs idle until real data shifts through.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) begin
            pipe_q[i] <= '1;
          end
        end else begin
          for (int i = 0; i < DEPTH; i++) begin
            pipe_q[i] <= pipe_d[i];
          end
        end
      end

      assign out_dat = pipe_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel/line counters, registered blank/sync decode, delayed syncs, frame events.
// Decoded outputs align with DrawX/DrawY; hs_d/vs_d lag by PIPE_DELAY; no backpressure.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_VISIBLE  = H_VISIBLE_DEF,
  parameter int H_FP       = H_FP_DEF,
  parameter int H_SYNC     = H_SYNC_DEF,
  parameter int H_BP       = H_BP_DEF,
  parameter int V_VISIBLE  = V_VISIBLE_DEF,
  parameter int V_FP       = V_FP_DEF,
  parameter int V_SYNC     = V_SYNC_DEF,
  parameter int V_BP       = V_BP_DEF,
  parameter int PIPE_DELAY = 1
) (
  input  logic        vga_clk,
  input  logic        reset_n,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
  output logic        blank,
  output logic        hs,
  output logic        vs,
  output logic        hs_d,
  output logic        vs_d,
  output logic        frame_start,
  output logic        vblank_start,
  output logic [15:0] frame_count
);

  localparam coord_t H_LAST    = coord_t'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
  localparam coord_t V_LAST    = coord_t'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
  localparam coord_t H_VIS_C   = coord_t'(H_VISIBLE);
  localparam coord_t V_VIS_C   = coord_t'(V_VISIBLE);
  localparam coord_t H_SYNC_LO = coord_t'(H_VISIBLE + H_FP);
  localparam coord_t H_SYNC_HI = coord_t'(H_VISIBLE + H_FP + H_SYNC);
  localparam coord_t V_SYNC_LO = coord_t'(V_VISIBLE + V_FP);
  localparam coord_t V_SYNC_HI = coord_t'(V_VISIBLE + V_FP + V_SYNC);

  coord_t      h_q, h_d;
  coord_t      v_q, v_d;
  logic        blank_q, blank_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        frame_start_q, frame_start_d;
  logic        vblank_start_q, vblank_start_d;
  logic [15:0] frame_count_q, frame_count_d;
  logic        h_wrap, v_wrap;
  logic [1:0]  sync_dly;

  // Outputs are decoded from next-state counters so they register in step with DrawX/DrawY.
  always_comb begin
    h_wrap = (h_q == H_LAST);
    v_wrap = (v_q == V_LAST);
    h_d    = h_wrap ? '0 : h_q + coord_t'(1);
    v_d    = v_q;
    if (h_wrap) begin
      v_d = v_wrap ? '0 : v_q + coord_t'(1);
    end
    blank_d        = (h_d < H_VIS_C) && (v_d < V_VIS_C);
    hsync_d        = !in_range(h_d, H_SYNC_LO, H_SYNC_HI);
    vsync_d        = !in_range(v_d, V_SYNC_LO, V_SYNC_HI);
    frame_start_d  = (h_d == '0) && (v_d == '0);
    vblank_start_d = (h_d == '0) && (v_d == V_VIS_C);
    frame_count_d  = frame_count_q;
    if (h_wrap && v_wrap) begin
      frame_count_d = frame_count_q + 16'd1;
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      h_q            <= '0;
      v_q            <= '0;
      blank_q        <= 1'b1;
      hsync_q        <= 1'b1;
      vsync_q        <= 1'b1;
      frame_start_q  <= 1'b0;
      vblank_start_q <= 1'b0;
      frame_count_q  <= '0;
    end else begin
      h_q            <= h_d;
      v_q            <= v_d;
      blank_q        <= blank_d;
      hsync_q        <= hsync_d;
      vsync_q        <= vsync_d;
      frame_start_q  <= frame_start_d;
      vblank_start_q <= vblank_start_d;
      frame_count_q  <= frame_count_d;
    end
  end

  sync_delay #(
    .DEPTH (PIPE_DELAY),
    .WIDTH (2)
  ) u_sync_delay (
    .clk     (vga_clk),
    .rst_n   (reset_n),
    .in_dat  ({hsync_q, vsync_q}),
    .out_dat (sync_dly)
  );

  assign DrawX        = h_q;
  assign DrawY        = v_q;
  assign blank        = blank_q;
  assign hs           = hsync_q;
  assign vs           = vsync_q;
  assign hs_d         = sync_dly[1];
  assign vs_d         = sync_dly[0];
  assign frame_start  = frame_start_q;
  assign vblank_start = vblank_start_q;
  assign frame_count  = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench on a shrunken raster (16x8 clocks per frame) with PIPE_DELAY=1 and 3 instances.
module tb_vga_timing_gen;

  localparam int HV = 8, HF = 2, HS = 3, HB = 3;
  localparam int VV = 4, VF = 1, VS = 2, VB = 1;
  localparam int HT = HV + HF + HS + HB;  // 16
  localparam int VT = VV + VF + VS + VB;  // 8
  localparam int FT = HT * VT;            // 128

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [9:0]  x1, y1, x3, y3;
  logic        b1, hs1, vs1, hsd1, vsd1, fs1, vb1;
  logic        b3, hs3, vs3, hsd3, vsd3, fs3, vb3;
  logic [15:0] fc1, fc3;

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .PIPE_DELAY(1)
  ) dut1 (
    .vga_clk(clk), .reset_n(rst_n), .DrawX(x1), .DrawY(y1), .blank(b1),
    .hs(hs1), .vs(vs1), .hs_d(hsd1), .vs_d(vsd1), .frame_start(fs1),
    .vblank_start(vb1), .frame_count(fc1)
  );

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .PIPE_DELAY(3)
  ) dut3 (
    .vga_clk(clk), .reset_n(rst_n), .DrawX(x3), .DrawY(y3), .blank(b3),
    .hs(hs3), .vs(vs3), .hs_d(hsd3), .vs_d(vsd3), .frame_start(fs3),
    .vblank_start(vb3), .frame_count(fc3)
  );

  int n = 0;
  int checks = 0;
  int passes = 0;

  typedef struct {
    int n; int x; int y; int blank; int hs; int vs; int fs; int vb; int fc;
  } vec_t;
  vec_t tv[16];

  // Reference raster: n = clock edges since reset release.
  function automatic int ex(int m); return m % HT; endfunction
  function automatic int ey(int m); return (m / HT) % VT; endfunction
  function automatic int e_hs(int m);
    if (m < 0) return 1;
    return (ex(m) >= HV + HF && ex(m) < HV + HF + HS) ? 0 : 1;
  endfunction
  function automatic int e_vs(int m);
    if (m < 0) return 1;
    return (ey(m) >= VV + VF && ey(m) < VV + VF + VS) ? 0 : 1;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s at n=%0d: got %0d expected %0d", nm, n, act, exp);
  endtask

  task automatic check_all(input int m, input int fc_exp);
    chk("DrawX", int'(x1), ex(m));
    chk("DrawY", int'(y1), ey(m));
    chk("blank", int'(b1), (ex(m) < HV && ey(m) < VV) ? 1 : 0);
    chk("hs", int'(hs1), e_hs(m));
    chk("vs", int'(vs1), e_vs(m));
    chk("frame_start", int'(fs1), (m > 0 && ex(m) == 0 && ey(m) == 0) ? 1 : 0);
    chk("vblank_start", int'(vb1), (ex(m) == 0 && ey(m) == VV) ? 1 : 0);
    chk("frame_count", int'(fc1), fc_exp);
    chk("hs_d1", int'(hsd1), e_hs(m - 1));
    chk("vs_d1", int'(vsd1), e_vs(m - 1));
    chk("hs_d3", int'(hsd3), e_hs(m - 3));
    chk("vs_d3", int'(vsd3), e_vs(m - 3));
    chk("DrawX3", int'(x3), ex(m));
  endtask

  task automatic step();
    @(posedge clk);
    n++;
    #1;
  endtask

  initial begin
    int hs_low, vs_low, blank_hi, fs_cnt, vb_cnt;

    tv[0]  = '{1,   1,  0, 1, 1, 1, 0, 0, 0};
    tv[1]  = '{7,   7,  0, 1, 1, 1, 0, 0, 0};
    tv[2]  = '{8,   8,  0, 0, 1, 1, 0, 0, 0};
    tv[3]  = '{9,   9,  0, 0, 1, 1, 0, 0, 0};
    tv[4]  = '{10, 10,  0, 0, 0, 1, 0, 0, 0};
    tv[5]  = '{12, 12,  0, 0, 0, 1, 0, 0, 0};
    tv[6]  = '{13, 13,  0, 0, 1, 1, 0, 0, 0};
    tv[7]  = '{15, 15,  0, 0, 1, 1, 0, 0, 0};
    tv[8]  = '{16,  0,  1, 1, 1, 1, 0, 0, 0};
    tv[9]  = '{64,  0,  4, 0, 1, 1, 0, 1, 0};
    tv[10] = '{79, 15,  4, 0, 1, 1, 0, 0, 0};
    tv[11] = '{80,  0,  5, 0, 1, 0, 0, 0, 0};
    tv[12] = '{111, 15, 6, 0, 1, 0, 0, 0, 0};
    tv[13] = '{112, 0,  7, 0, 1, 1, 0, 0, 0};
    tv[14] = '{128, 0,  0, 1, 1, 1, 1, 0, 1};
    tv[15] = '{129, 1,  0, 1, 1, 1, 0, 0, 1};

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check_all(0, 0);
    chk("rst_hs_d3", int'(hsd3), 1);

    @(negedge clk);
    rst_n = 1'b1;
    n = 0;

    for (int i = 0; i < 16; i++) begin
      while (n < tv[i].n) step();
      chk("tv_DrawX", int'(x1), tv[i].x);
      chk("tv_DrawY", int'(y1), tv[i].y);
      chk("tv_blank", int'(b1), tv[i].blank);
      chk("tv_hs", int'(hs1), tv[i].hs);
      chk("tv_vs", int'(vs1), tv[i].vs);
      chk("tv_frame_start", int'(fs1), tv[i].fs);
      chk("tv_vblank_start", int'(vb1), tv[i].vb);
      chk("tv_frame_count", int'(fc1), tv[i].fc);
    end

    // Cycle-by-cycle sweep with per-frame pulse counts over the third frame.
    hs_low = 0; vs_low = 0; blank_hi = 0; fs_cnt = 0; vb_cnt = 0;
    while (n < 3 * FT + 3) begin
      step();
      check_all(n, n / FT);
      if (n >= 2 * FT && n < 3 * FT) begin
        hs_low   += (hs1 == 1'b0) ? 1 : 0;
        vs_low   += (vs1 == 1'b0) ? 1 : 0;
        blank_hi += (b1 == 1'b1) ? 1 : 0;
        fs_cnt   += (fs1 == 1'b1) ? 1 : 0;
        vb_cnt   += (vb1 == 1'b1) ? 1 : 0;
      end
    end
    chk("hs_low_per_frame", hs_low, HS * VT);
    chk("vs_low_per_frame", vs_low, VS * HT);
    chk("blank_hi_per_frame", blank_hi, HV * VV);
    chk("frame_start_count", fs_cnt, 1);
    chk("vblank_start_count", vb_cnt, 1);

    // Asynchronous mid-frame reset at (5,2), asserted between clock edges.
    while ((n % FT) != 2 * HT + 5) step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_DrawX", int'(x1), 0);
    chk("arst_DrawY", int'(y1), 0);
    chk("arst_blank", int'(b1), 1);
    chk("arst_hs", int'(hs1), 1);
    chk("arst_vs", int'(vs1), 1);
    chk("arst_hs_d3", int'(hsd3), 1);
    chk("arst_vs_d3", int'(vsd3), 1);
    chk("arst_frame_count", int'(fc1), 0);
    repeat (5) @(posedge clk);
    #1;
    check_all(0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (n < 20) begin
      step();
      check_all(n, 0);
    end

    // frame_count rollover: preload 0xFFFF, next frame wrap must give 0.
    @(negedge clk);
    force dut1.frame_count_q = 16'hFFFF;
    @(posedge clk);
    n++;
    #1;
    release dut1.frame_count_q;
    chk("fc_preload", int'(fc1), 16'hFFFF);
    while (n < FT - 1) step();
    chk("fc_hold_before_wrap", int'(fc1), 16'hFFFF);
    step();
    chk("fc_rollover", int'(fc1), 0);
    chk("fc_rollover_frame_start", int'(fs1), 1);
    chk("fc_dut3_unaffected", int'(fc3), 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates 640x480@60 Hz VGA raster timing from the 25 MHz pixel clock and feeds the sprite/palette drawing stages directly downstream. Produces the pixel coordinates `DrawX`/`DrawY`, the active-video flag `blank`, and raw sync pulses. It also produces sync pulses delayed to match the drawing stages' one-cycle colour latency, plus frame-boundary events consumed by sprite animation logic.

## Interface
Parameters:
- `H_VISIBLE`, 640, active pixels per line
- `H_FP`, 16, horizontal front porch (clocks)
- `H_SYNC`, 96, horizontal sync width
- `H_BP`, 48, horizontal back porch
- `V_VISIBLE`, 480, active lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width
- `V_BP`, 33, vertical back porch
- `PIPE_DELAY`, 1, clocks of delay applied to `hs_d`/`vs_d`; legal range 0..4

Ports:
- `vga_clk`  in  1  pixel clock (25 MHz)
- `reset_n`  in  1  asynchronous, active-low reset
- `DrawX`  out  10  current column, 0..799
- `DrawY`  out  10  current line, 0..524
- `blank`  out  1  1 = active video (DrawX<640 and DrawY<480); downstream drives colour only when high
- `hs`  out  1  horizontal sync, active-low
- `vs`  out  1  vertical sync, active-low
- `hs_d`  out  1  `hs` delayed by PIPE_DELAY clocks
- `vs_d`  out  1  `vs` delayed by PIPE_DELAY clocks
- `frame_start`  out  1  one-clock pulse while DrawX=0, DrawY=0
- `vblank_start`  out  1  one-clock pulse while DrawX=0, DrawY=V_VISIBLE
- `frame_count`  out  16  frames completed since reset

## Operation
- H_TOTAL = sum of the H parameters (800); V_TOTAL = sum of the V parameters (525).
- Horizontal counter increments every clock and wraps from H_TOTAL-1 to 0.
- On horizontal wrap, the vertical counter increments, wrapping from V_TOTAL-1 to 0.
- `DrawX`/`DrawY` are the counter registers themselves. They are not delayed.
- `hs`, `vs`, and `blank` are registered outputs, decoded from the counters' next-state values, so they align with `DrawX`/`DrawY` on the same cycle.
- `hs` is low when H_VISIBLE+H_FP ≤ DrawX < H_VISIBLE+H_FP+H_SYNC (656..751).
- `vs` is low when V_VISIBLE+V_FP ≤ DrawY < V_VISIBLE+V_FP+V_SYNC (490..491).
- `hs_d`/`vs_d` come from a PIPE_DELAY-deep shift register. Its reset value is 1, so no spurious sync occurs after reset. With PIPE_DELAY=0 they equal `hs`/`vs`.
- `frame_count` increments on the clock where the counters wrap from (799,524) to (0,0), i.e. coincident with `frame_start` rising. It wraps from 0xFFFF to 0.
- Arithmetic: all counters are 10-bit unsigned; comparisons are against elaborated constants; there are no multipliers.

## Timing
- Reset (`reset_n` low, asynchronous): DrawX=0, DrawY=0, blank=1, hs=1, vs=1, hs_d=1, vs_d=1, frame_start=0, vblank_start=0, frame_count=0.
- First clock edge after reset release: DrawX=1, frame_start=0.
  - The (0,0) pixel after reset does not assert `frame_start`.
  - The first `frame_start` occurs 420000 clocks after release.
  - `frame_count` is still 0 until that wrap.
- Line period is 800 clocks; frame period is 420000 clocks.
- `hs` low for exactly 96 clocks per line; `vs` low for exactly 1600 clocks per frame.
- `vs` edges coincide with DrawX=0 (vs changes on the horizontal-wrap edge).
- `blank` high for 640 clocks per active line, low for all lines ≥480.
- Reset asserted mid-frame: all outputs return to their reset values immediately. The delay line is also cleared to 1.

## Structure
- A shared package `vga_pkg` holds the default timing constants, H_TOTAL/V_TOTAL, and the coordinate typedef `coord_t` (logic [9:0]). The drawing stages import the same package.
- One sub-module is natural: `sync_delay` (parameterised depth, reset value 1), instantiated twice or as 2-bit wide.

## Test plan
- Reset then release: check reset values. After 799 clocks DrawX=799, DrawY=0; next clock DrawX=0, DrawY=1.
- Run one full line: `hs` falls when DrawX=656, rises at DrawX=752; `blank` falls at DrawX=640, rises at DrawX=0.
- Run one full frame: `vs` low exactly for DrawY 490..491 (1600 clocks). `vblank_start` pulses once at (0,480). `frame_start` pulses once at clock 420000 and `frame_count` becomes 1.
- PIPE_DELAY=1 and PIPE_DELAY=3 builds: `hs_d` equals `hs` shifted by exactly 1 and 3 clocks over a full frame.
- Assert `reset_n` at (300,200) for 5 clocks, asynchronously mid-cycle: outputs reach reset values before the next edge, and counting restarts from (0,0).
- Force `frame_count` to 0xFFFF via 65535 frame wraps (or a shortened-parameter build, e.g. H_TOTAL=8, V_TOTAL=4): the next wrap gives 0.
